// File: rtl/mem_seq_pkg.sv
// Shared encodings for the memory access sequencer: op codes, FSM states,
// lane width and the alignment rule used when a request is accepted.
package mem_seq_pkg;

    localparam int LANE_W = 8;

    localparam logic [2:0] OP_LW = 3'd0;
    localparam logic [2:0] OP_LH = 3'd1;
    localparam logic [2:0] OP_LB = 3'd2;
    localparam logic [2:0] OP_SW = 3'd4;
    localparam logic [2:0] OP_SH = 3'd5;
    localparam logic [2:0] OP_SB = 3'd6;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_WAIT = 3'd1,
        CAP     = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4,
        ERR     = 3'd5
    } state_e;

    // High when the request must be rejected: misaligned word/half or reserved op.
    function automatic logic bad_access(input logic [2:0] op, input logic [1:0] off);
        case (op)
            OP_LW, OP_SW: bad_access = (off != 2'b00);
            OP_LH, OP_SH: bad_access = off[0];
            OP_LB, OP_SB: bad_access = 1'b0;
            default:      bad_access = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_seq_byte_lane_unit.sv
// Byte-lane steering shared by the load path (extract + zero-extend) and the
// sub-word store path (merge new lane(s) into the word read from memory).
module byte_lane_unit
    import mem_seq_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    logic [4:0]        w_bit_base;
    logic [LANE_W-1:0] w_byte;
    logic [15:0]       w_half;

    assign w_bit_base = {i_offset, 3'b000};
    assign w_byte     = i_word[w_bit_base +: LANE_W];
    assign w_half     = i_offset[1] ? i_word[31:16] : i_word[15:0];

    // NOTE: every output gets a default first so no path through the case infers a latch.
    always_comb begin
        o_load   = i_word;
        o_merged = i_word;
        case (i_op)
            OP_LH:   o_load = {16'h0000, w_half};
            OP_LB:   o_load = {24'h00_0000, w_byte};
            OP_SH: begin
                if (i_offset[1]) o_merged[31:16] = i_wdata[15:0];
                else             o_merged[15:0]  = i_wdata[15:0];
            end
            OP_SB:   o_merged[w_bit_base +: LANE_W] = i_wdata[LANE_W-1:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_seq.sv
// Multicycle load/store sequencer owning a single-ported memory: read wait
// states, read-modify-write for sub-word stores, misalignment rejection.
module mem_access_seq
    import mem_seq_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        exc,
    output logic [31:0] rdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

    state_e      r_state;
    state_e      w_next_state;
    logic [2:0]  r_op;
    logic [1:0]  r_off;
    logic [31:0] r_wdata;
    logic [2:0]  r_cnt;
    logic [31:0] r_rdata;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_wr;
    logic        w_accept;
    logic        w_sub_store;
    logic [31:0] w_load;
    logic [31:0] w_merged;

    assign w_accept    = (r_state == IDLE) && req;
    assign w_sub_store = (r_op == OP_SH) || (r_op == OP_SB);

    byte_lane_unit u_lanes (
        .i_word   (mem_rdata),
        .i_offset (r_off),
        .i_op     (r_op),
        .i_wdata  (r_wdata),
        .o_load   (w_load),
        .o_merged (w_merged)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (req) begin
                    if (bad_access(op, addr[1:0])) w_next_state = ERR;
                    else if (op == OP_SW)          w_next_state = WR;
                    else                           w_next_state = RD_WAIT;
                end
            end
            RD_WAIT: if (r_cnt == 3'd0) w_next_state = CAP;
            CAP:     w_next_state = w_sub_store ? WR : DONE;
            WR:      w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            ERR:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state != IDLE);
        done = (r_state == DONE);
        exc  = (r_state == ERR);
    end

    // Datapath registers; mem_wr is a flop so it is exactly the WR cycle and glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_op        <= OP_LW;
            r_off       <= 2'b00;
            r_wdata     <= '0;
            r_cnt       <= '0;
            r_rdata     <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wr    <= 1'b0;
        end else begin
            r_mem_wr <= (w_next_state == WR);
            if (w_accept) begin
                r_op       <= op;
                r_off      <= addr[1:0];
                r_wdata    <= wdata;
                r_mem_addr <= {addr[31:2], 2'b00};
                r_cnt      <= LAT_INIT;
                if (op == OP_SW) r_mem_wdata <= wdata;
            end
            if (r_state == RD_WAIT && r_cnt != 3'd0) r_cnt <= r_cnt - 3'd1;
            if (r_state == CAP) begin
                if (w_sub_store) r_mem_wdata <= w_merged;
                else             r_rdata     <= w_load;
            end
        end
    end

    assign rdata     = r_rdata;
    assign mem_addr  = r_mem_addr;
    assign mem_wr    = r_mem_wr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: directed requests push expectations,
// a negedge monitor pops and compares on every done/exc pulse.
module tb_mem_access_seq;

    localparam int MEM_LAT = 2;
    localparam logic [2:0] LW = 3'd0, LH = 3'd1, LB = 3'd2, SW = 3'd4, SH = 3'd5, SB = 3'd6;

    logic        clk;
    logic        reset;
    logic        req;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        exc;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic        mem_wr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_access_seq #(.MEM_LAT(MEM_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .exc       (exc),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_wr    (mem_wr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_exc;
        int          lat;
        logic [31:0] rdata;
        int          nwr;
        logic [31:0] maddr;
        logic [31:0] wr_data;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory model: data is valid only once the address has been held for MEM_LAT cycles.
    logic [31:0] mem [0:63];
    bit          mem_init_done = 0;
    int          rd_cnt = 0;

    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 64; i++) mem[i] = 32'h0;
            mem[4] = 32'hDEAD_BEEF;
            mem[8] = 32'h1122_3344;
            mem_init_done = 1;
        end else if (mem_wr) begin
            mem[mem_addr[7:2]] = mem_wdata;
        end
    end

    always @(negedge clk) begin
        if (reset || !busy) rd_cnt = 0;
        else                rd_cnt = rd_cnt + 1;
    end

    assign mem_rdata = (rd_cnt > MEM_LAT) ? mem[mem_addr[7:2]] : 32'hBAD0_BAD0;

    // Monitor
    bit          inflight = 0;
    bit          post_end = 0;
    bit          addr_moved = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    logic [31:0] a0, wr_addr, wr_data;
    exp_t        e;

    always @(negedge clk) begin
        if (reset) begin
            inflight = 0;
            post_end = 0;
            wr_cnt   = 0;
        end else begin
            if (post_end) begin
                check("busy_after_end", 32'(busy), 32'd0);
                post_end = 0;
            end
            if (inflight) begin
                cyc++;
                if (cyc == 1)              a0 = mem_addr;
                else if (mem_addr !== a0)  addr_moved = 1;
            end
            if (mem_wr) begin
                if (!inflight) check("stray_mem_wr", 32'(mem_wr), 32'd0);
                wr_cnt++;
                wr_addr = mem_addr;
                wr_data = mem_wdata;
            end
            if (done || exc) begin
                check("done_exc_exclusive", 32'(done && exc), 32'd0);
                if (q.size() == 0) begin
                    check("unexpected_end", 32'(q.size()), 32'd1);
                end else begin
                    e = q.pop_front();
                    check("kind_exc", 32'(exc), 32'(e.is_exc));
                    check("latency", 32'(cyc), 32'(e.lat));
                    check("rdata", rdata, e.rdata);
                    check("wr_count", 32'(wr_cnt), 32'(e.nwr));
                    if (!e.is_exc) begin
                        check("mem_addr", a0, e.maddr);
                        check("addr_stable", 32'(addr_moved), 32'd0);
                    end
                    if (e.nwr > 0) begin
                        check("wr_addr", wr_addr, e.maddr);
                        check("wr_data", wr_data, e.wr_data);
                    end
                end
                inflight = 0;
                post_end = 1;
            end
            if (req && !busy) begin
                inflight   = 1;
                cyc        = 0;
                wr_cnt     = 0;
                addr_moved = 0;
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        do begin
            @(posedge clk);
            #2;
            n++;
        end while (busy && n < 200);
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w);
        wait_idle();
        req   = 1'b1;
        op    = o;
        addr  = a;
        wdata = w;
        @(posedge clk);
        #2;
        req = 1'b0;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] w,
                         input bit x, input int lat, input int nwr,
                         input logic [31:0] wd, input logic [31:0] rd);
        exp_t t;
        t.is_exc  = x;
        t.lat     = lat;
        t.rdata   = rd;
        t.nwr     = nwr;
        t.maddr   = {a[31:2], 2'b00};
        t.wr_data = wd;
        q.push_back(t);
        drive(o, a, w);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_exc"}, 32'(exc), 32'd0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_mem_addr"}, mem_addr, 32'd0);
        check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    localparam int LD = MEM_LAT + 2;
    localparam int RMW = MEM_LAT + 3;

    initial begin
        reset = 1'b0;
        req   = 1'b0;
        op    = 3'd0;
        addr  = 32'd0;
        wdata = 32'd0;
        #3 reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 check_all_zero("reset");
        reset = 1'b0;

        issue(LW, 32'h10, 32'h0,         0, LD,  0, 32'h0,         32'hDEAD_BEEF);
        issue(SW, 32'h10, 32'h8877_6655, 0, 2,   1, 32'h8877_6655, 32'hDEAD_BEEF);
        issue(LB, 32'h13, 32'h0,         0, LD,  0, 32'h0,         32'h0000_0088);
        issue(LH, 32'h12, 32'h0,         0, LD,  0, 32'h0,         32'h0000_8877);
        issue(LH, 32'h10, 32'h0,         0, LD,  0, 32'h0,         32'h0000_6655);
        issue(LB, 32'h11, 32'h0,         0, LD,  0, 32'h0,         32'h0000_0066);
        issue(SB, 32'h21, 32'h0000_00AB, 0, RMW, 1, 32'h1122_AB44, 32'h0000_0066);
        issue(SH, 32'h22, 32'h5566_BEEF, 0, RMW, 1, 32'hBEEF_AB44, 32'h0000_0066);
        issue(LW, 32'h20, 32'h0,         0, LD,  0, 32'h0,         32'hBEEF_AB44);
        issue(SW, 32'h08, 32'hCAFE_F00D, 0, 2,   1, 32'hCAFE_F00D, 32'hBEEF_AB44);
        issue(LW, 32'h08, 32'h0,         0, LD,  0, 32'h0,         32'hCAFE_F00D);
        issue(LW, 32'h06, 32'h0,         1, 1,   0, 32'h0,         32'hCAFE_F00D);
        issue(SH, 32'h03, 32'hFFFF_FFFF, 1, 1,   0, 32'h0,         32'hCAFE_F00D);
        issue(3'd3, 32'h10, 32'h0,       1, 1,   0, 32'h0,         32'hCAFE_F00D);
        issue(3'd7, 32'h10, 32'h0,       1, 1,   0, 32'h0,         32'hCAFE_F00D);
        issue(SB, 32'h03, 32'h0000_0077, 0, RMW, 1, 32'h7700_0000, 32'hCAFE_F00D);
        issue(LB, 32'h03, 32'h0,         0, LD,  0, 32'h0,         32'h0000_0077);

        // Abort an SH during its read wait; memory at 0x20 must stay untouched.
        drive(SH, 32'h22, 32'h0000_1234);
        @(negedge clk);
        #1 reset = 1'b1;
        #1 check_all_zero("mid_rmw_reset");
        @(posedge clk);
        #2 reset = 1'b0;

        issue(LW, 32'h20, 32'h0, 0, LD, 0, 32'h0, 32'hBEEF_AB44);
        @(posedge clk);
        #2;
        req   = 1'b1;
        op    = SW;
        addr  = 32'h20;
        wdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #2 req = 1'b0;
        issue(LW, 32'h20, 32'h0, 0, LD, 0, 32'h0, 32'hBEEF_AB44);

        wait_idle();
        repeat (3) @(posedge clk);
        check("pending_expectations", 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared / %0d mismatched", n_cmp, n_bad);
        $fatal(1);
    end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- Multicycle sequencer that owns the single-ported byte-addressed memory on behalf of the main control FSM.
- Turns one load/store request (word, halfword, byte) into the correct sequence of memory cycles: read wait states, read-modify-write for sub-word stores, byte-lane extraction for sub-word loads.
- Flags misaligned accesses so control can raise an exception without touching memory.
- Sits between the control unit and the memory; its loaded word feeds the MemToReg mux path.

Parameters:
- MEM_LAT, 2, cycles from mem_addr stable to mem_rdata valid; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  1  request strobe from control; sampled only in IDLE
- op  in  3  access type: 0 LW, 1 LH, 2 LB, 4 SW, 5 SH, 6 SB; 3 and 7 are reserved
- addr  in  32  byte address, ALUOut value
- wdata  in  32  store data, B register; low byte/half used for SB/SH
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse; access complete, rdata valid in the same cycle
- exc  out  1  one-cycle pulse; misaligned access or reserved op
- rdata  out  32  load result, zero-extended for LH/LB; holds until next done
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00} to memory
- mem_wr  out  1  memory write enable, registered
- mem_wdata  out  32  word written to memory
- mem_rdata  in  32  memory read data

Behaviour:
- Byte lanes: byte offset k = addr[1:0] occupies bits [8k+7:8k]. Halfword at offset 0 uses [15:0]; at offset 2 uses [31:16].
- Reset (async): state IDLE; busy, done, exc, mem_wr = 0; rdata, mem_addr, mem_wdata = 0; wait counter = 0.
- IDLE, req=0: stay.
- IDLE, req=1: latch op, addr, wdata. Then branch on the request:
  - Misaligned (LW/SW with addr[1:0]≠0; LH/SH with addr[0]=1) or reserved op: go to ERR.
  - LW/LH/LB/SH/SB: go to RD_WAIT, counter = MEM_LAT−1.
  - SW: go to WR.
- RD_WAIT: mem_addr driven, mem_wr=0. If counter=0, go to CAP; else decrement.
- CAP: capture mem_rdata.
  - Loads: extract the word/half/byte into rdata, go to DONE.
  - SH/SB: form mem_wdata = captured word with the selected lane(s) replaced by wdata[15:0]/wdata[7:0], go to WR.
- WR: mem_wr=1 for exactly this one cycle. mem_wdata = wdata for SW, merged word for SH/SB. Go to DONE.
- DONE: done=1 for one cycle, go to IDLE.
- ERR: exc=1 for one cycle, no mem_wr, rdata unchanged, go to IDLE.
- Latency from the accepting edge to done high:
  - SW: 2 cycles
  - Loads: MEM_LAT+2 cycles
  - SH/SB: MEM_LAT+3 cycles
  - Misaligned/reserved: exc high 1 cycle after acceptance
- req outside IDLE (including DONE/ERR): ignored, not queued. Control must hold or re-assert req.
- mem_addr is stable from RD_WAIT through WR of a single access. It must not change between the read and the write of a RMW.
- Reset asserted mid-RMW: mem_wr drops immediately (async clear) and no partial write occurs after reset. The next access starts cleanly from IDLE.
- done and exc are never high together. busy=0 in the cycle after done/exc.

Decomposition:
- Shared package mem_seq_pkg holds:
  - op encodings OP_LW/OP_LH/OP_LB/OP_SW/OP_SH/OP_SB
  - state enum IDLE/RD_WAIT/CAP/WR/DONE/ERR
  - helper constant for lane width
- One natural combinational sub-module, byte_lane_unit:
  - inputs: captured word, offset, op, wdata
  - outputs: extracted zero-extended load value and merged store word
  - reused by both load and sub-word store paths.

Test Plan:
- LW addr=0x0000_0010, memory word 0xDEAD_BEEF, MEM_LAT=2 -> done 4 cycles after acceptance, rdata=0xDEAD_BEEF, mem_wr never high.
- LB addr=0x13, word 0x8877_6655 -> rdata=0x0000_0088. LH addr=0x12 on the same word -> rdata=0x0000_8877.
- SB addr=0x21, wdata=0x0000_00AB, old word 0x1122_3344 -> one mem_wr pulse with mem_wdata=0x1122_AB44, mem_addr=0x20, done 5 cycles after acceptance.
- SW addr=0x08, wdata=0xCAFE_F00D -> mem_wr high exactly 1 cycle, done 2 cycles after acceptance, no read wait.
- LW addr=0x06, then SH addr=0x03, then op=3 -> each gives an exc pulse 1 cycle after acceptance, no mem_wr, rdata unchanged.
- SH started and reset asserted during RD_WAIT -> all outputs 0 asynchronously, no mem_wr. A following LW completes normally. A req pulsed during busy is ignored.
